vga_scan_ctrl: RTL and testbench
================================

VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 The block SHALL have parameters, one per line (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front-porch pixels
- H_SYNC, 96, horizontal sync pixels
- H_BP, 48, horizontal back-porch pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front-porch lines
- V_SYNC, 2, vertical sync lines
- V_BP, 33, vertical back-porch lines

REQ-002 The block SHALL have ports, one per line (name  direction  width  meaning):
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  reset, synchronous, active-high
- posx  output  11  current pixel column, 0..H_TOTAL-1
- posy  output  11  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- video_on  output  1  high when posx<H_ACTIVE and posy<V_ACTIVE
- pix_tick  output  1  pixel-advance enable
- line_end  output  1  one-clk pulse on the last pixel of a line
- frame_end  output  1  one-clk pulse on the last pixel of a frame

Function
REQ-003 Line and frame totals SHALL be H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-004 posx, posy, hsync, vsync and video_on SHALL be registered and SHALL change only on clk edges where pix_tick=1.
REQ-005 The horizontal FSM SHALL have states H_ACT (posx 0..639), H_FP (640..655), H_SYNC (656..751) and H_BP (752..799), advancing in the order ACT->FP->SYNC->BP->ACT.
REQ-006 The vertical FSM SHALL have states V_ACT (posy 0..479), V_FP (480..489), V_SYNC (490..491) and V_BP (492..524), advancing only when line_end=1.
REQ-007 posx SHALL increment by 1 per pix_tick and wrap from H_TOTAL-1 to 0.
REQ-008 On the posx wrap, posy SHALL increment by 1 and wrap from V_TOTAL-1 to 0.
REQ-009 hsync SHALL be 0 exactly while the horizontal FSM is in H_SYNC and 1 otherwise.
REQ-010 vsync SHALL be 0 exactly while the vertical FSM is in V_SYNC and 1 otherwise.
REQ-011 video_on SHALL be 1 only when both FSMs are in their ACT states, and SHALL be aligned with posx/posy in the same cycle.
REQ-012 line_end SHALL equal (posx==H_TOTAL-1 && pix_tick), giving exactly one clk-wide pulse per line.
REQ-013 frame_end SHALL equal (line_end && posy==V_TOTAL-1).
REQ-014 Counter arithmetic SHALL be 11-bit unsigned and SHALL NOT exceed H_TOTAL-1 or V_TOTAL-1 under any stimulus.

Reset
REQ-015 While reset=1 at a clk edge, the block SHALL load posx=0, posy=0, H_ACT, V_ACT, hsync=1, vsync=1, video_on=1 and clear the pixel divider phase.
REQ-016 Reset SHALL override any in-progress line or frame; the first edge after release SHALL resume from (0,0) with no partial sync pulse.
REQ-017 line_end and frame_end SHALL be 0 during reset.

Configuration
REQ-018 When macro VGA_PIXEL_DIV2_EN is defined, pix_tick SHALL be an internal toggle (0 on the first clk after reset, then alternating), so one pixel occupies 2 clks (a 50 MHz clk gives a 25 MHz pixel rate).
REQ-019 When VGA_PIXEL_DIV2_EN is undefined, pix_tick SHALL be constant 1 and one pixel SHALL occupy 1 clk.

Verification
REQ-020 Macro off, reset then 640 clks -> posx=640, posy=0, video_on=0, hsync=1.
REQ-021 Macro off, run one line -> hsync=0 for exactly posx 656..751 (96 clks); line_end pulses once at posx=799; next cycle posx=0, posy=1.
REQ-022 Macro off, run 420000 clks -> vsync=0 for exactly posy 490..491; frame_end pulses once at (799,524); next cycle (0,0) with video_on=1.
REQ-023 Macro off, assert reset for 1 clk at (300,100) -> next cycle (0,0), hsync=1, vsync=1; after 300 clks posx=300, posy=0.
REQ-024 Macro on, reset then 10 clks -> pix_tick pattern 0,1,0,1,..., posx=5; one line takes 1600 clks; line_end is 1 clk wide.
REQ-025 Scenarios REQ-020 to REQ-024 SHALL also check video_on=0 whenever posx>=640 or posy>=480.

Source files
------------

// File: rtl/vga_scan_ctrl.sv
// VGA raster timing generator: horizontal/vertical phase FSMs plus pixel/line counters.
// Build option VGA_PIXEL_DIV2_EN: one pixel every second clk; otherwise one pixel per clk.
module vga_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] posx,
  output logic [10:0] posy,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        pix_tick,
  output logic        line_end,
  output logic        frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_FP_START   = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_BP_START   = 11'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_FP_START   = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_BP_START   = 11'(V_ACTIVE + V_FP + V_SYNC);

  // State names carry an ST_ prefix because H_FP/H_SYNC/... are already parameters.
  typedef enum logic [1:0] {
    ST_H_ACT  = 2'd0,
    ST_H_FP   = 2'd1,
    ST_H_SYNC = 2'd2,
    ST_H_BP   = 2'd3
  } h_state_e;

  typedef enum logic [1:0] {
    ST_V_ACT  = 2'd0,
    ST_V_FP   = 2'd1,
    ST_V_SYNC = 2'd2,
    ST_V_BP   = 2'd3
  } v_state_e;

  h_state_e    h_state_q, h_state_d;
  v_state_e    v_state_q, v_state_d;
  logic [10:0] posx_q, posx_d;
  logic [10:0] posy_q, posy_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        video_on_q, video_on_d;

`ifdef VGA_PIXEL_DIV2_EN
  logic phase_q, phase_d;

  always_comb begin
    phase_d = ~phase_q;
    if (reset) begin
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    phase_q <= phase_d;
  end

  assign pix_tick = phase_q;
`else
  assign pix_tick = 1'b1;
`endif

  // Combinational strobes; the reset gate keeps them quiet while reset is held.
  assign line_end  = pix_tick && (posx_q == H_LAST) && !reset;
  assign frame_end = line_end && (posy_q == V_LAST);

  always_comb begin
    posx_d    = posx_q;
    h_state_d = h_state_q;
    hsync_d   = hsync_q;
    if (pix_tick) begin
      posx_d = (posx_q >= H_LAST) ? 11'd0 : posx_q + 11'd1;
      unique case (h_state_q)
        ST_H_ACT:  if (posx_d == H_FP_START)   h_state_d = ST_H_FP;
        ST_H_FP:   if (posx_d == H_SYNC_START) h_state_d = ST_H_SYNC;
        ST_H_SYNC: if (posx_d == H_BP_START)   h_state_d = ST_H_BP;
        ST_H_BP:   if (posx_d == 11'd0)        h_state_d = ST_H_ACT;
        default:                               h_state_d = ST_H_ACT;
      endcase
      hsync_d = (h_state_d != ST_H_SYNC);
    end
    if (reset) begin
      posx_d    = 11'd0;
      h_state_d = ST_H_ACT;
      hsync_d   = 1'b1;
    end
  end

  always_comb begin
    posy_d    = posy_q;
    v_state_d = v_state_q;
    vsync_d   = vsync_q;
    if (line_end) begin
      posy_d = (posy_q >= V_LAST) ? 11'd0 : posy_q + 11'd1;
      unique case (v_state_q)
        ST_V_ACT:  if (posy_d == V_FP_START)   v_state_d = ST_V_FP;
        ST_V_FP:   if (posy_d == V_SYNC_START) v_state_d = ST_V_SYNC;
        ST_V_SYNC: if (posy_d == V_BP_START)   v_state_d = ST_V_BP;
        ST_V_BP:   if (posy_d == 11'd0)        v_state_d = ST_V_ACT;
        default:                               v_state_d = ST_V_ACT;
      endcase
      vsync_d = (v_state_d != ST_V_SYNC);
    end
    if (reset) begin
      posy_d    = 11'd0;
      v_state_d = ST_V_ACT;
      vsync_d   = 1'b1;
    end
  end

  // Derived from the next states so blanking lines up with the registered position.
  always_comb begin
    video_on_d = (h_state_d == ST_H_ACT) && (v_state_d == ST_V_ACT);
  end

  always_ff @(posedge clk) begin
    h_state_q  <= h_state_d;
    v_state_q  <= v_state_d;
    posx_q     <= posx_d;
    posy_q     <= posy_d;
    hsync_q    <= hsync_d;
    vsync_q    <= vsync_d;
    video_on_q <= video_on_d;
  end

  assign posx     = posx_q;
  assign posy     = posy_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = video_on_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl: a default-geometry instance and a small-geometry
// instance (full frames fit in the run) are checked every cycle against a pixel-count model.
module tb_vga_scan_ctrl;

`ifdef VGA_PIXEL_DIV2_EN
  localparam bit DIV2 = 1'b1;
`else
  localparam bit DIV2 = 1'b0;
`endif

  localparam int NCYC   = 60000;
  localparam int RST_AT = 800 * 20 + 700;

  localparam int S_HA = 40;
  localparam int S_HF = 5;
  localparam int S_HS = 10;
  localparam int S_HB = 7;
  localparam int S_VA = 12;
  localparam int S_VF = 2;
  localparam int S_VS = 3;
  localparam int S_VB = 4;

  logic clk;
  logic reset;

  logic [10:0] posx0, posy0, posx1, posy1;
  logic        hsync0, vsync0, von0, tick0, le0, fe0;
  logic        hsync1, vsync1, von1, tick1, le1, fe1;

  vga_scan_ctrl u_dut_def (
    .clk(clk), .reset(reset), .posx(posx0), .posy(posy0), .hsync(hsync0), .vsync(vsync0),
    .video_on(von0), .pix_tick(tick0), .line_end(le0), .frame_end(fe0)
  );

  vga_scan_ctrl #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) u_dut_small (
    .clk(clk), .reset(reset), .posx(posx1), .posy(posy1), .hsync(hsync1), .vsync(vsync1),
    .video_on(von1), .pix_tick(tick1), .line_end(le1), .frame_end(fe1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [27:0] o0;
    logic [27:0] o1;
  } exp_t;

  exp_t sb_q[$];
  exp_t exp_item;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt;
  bit   ph;
  int   rst_left = 0;

  // Expected outputs from the number of pixels elapsed since reset.
  function automatic logic [27:0] model_out(int inst, int pix, bit phase, bit rst);
    int ha, hf, hs, hb, va, vf, vs, vb, ht, vt, x, y;
    logic e_hs, e_vs, e_von, e_tick, e_le, e_fe;
    if (inst == 0) begin
      ha = 640; hf = 16; hs = 96; hb = 48; va = 480; vf = 10; vs = 2; vb = 33;
    end else begin
      ha = S_HA; hf = S_HF; hs = S_HS; hb = S_HB; va = S_VA; vf = S_VF; vs = S_VS; vb = S_VB;
    end
    ht     = ha + hf + hs + hb;
    vt     = va + vf + vs + vb;
    x      = pix % ht;
    y      = (pix / ht) % vt;
    e_hs   = !(x >= ha + hf && x < ha + hf + hs);
    e_vs   = !(y >= va + vf && y < va + vf + vs);
    e_von  = (x < ha) && (y < va);
    e_tick = DIV2 ? phase : 1'b1;
    e_le   = e_tick && (x == ht - 1) && !rst;
    e_fe   = e_le && (y == vt - 1);
    return {11'(x), 11'(y), e_hs, e_vs, e_von, e_tick, e_le, e_fe};
  endfunction

  task automatic check(input int inst, input logic [27:0] got, input logic [27:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL scan%0d t=%0t got x=%0d y=%0d hs/vs/von/tick/le/fe=%b%b%b%b%b%b need x=%0d y=%0d hs/vs/von/tick/le/fe=%b%b%b%b%b%b",
               inst, $time, got[27:17], got[16:6], got[5], got[4], got[3], got[2], got[1], got[0],
               exp[27:17], exp[16:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic bit pick_reset(int c);
    if (c < 3 || c == RST_AT) return 1'b1;
    if (rst_left > 0) begin
      rst_left--;
      return 1'b1;
    end
    if ($urandom_range(0, 14999) == 0) begin
      rst_left = $urandom_range(0, 2);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    reset = 1'b1;
    cnt   = 0;
    ph    = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      if (reset) begin
        cnt = 0;
        ph  = 1'b0;
      end else begin
        if (!DIV2 || ph) cnt++;
        ph = ~ph;
      end
      #1;
      reset = pick_reset(c);
      sb_q.push_back('{o0: model_out(0, cnt, ph, reset), o1: model_out(1, cnt, ph, reset)});
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending need=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_item = sb_q.pop_front();
      check(0, {posx0, posy0, hsync0, vsync0, von0, tick0, le0, fe0}, exp_item.o0);
      check(1, {posx1, posy1, hsync1, vsync1, von1, tick1, le1, fe1}, exp_item.o1);
    end
  end

endmodule
